// File: rtl/sad_result_reporter.sv
// sad_result_reporter
// Buffers SAD search match addresses and, once the search finishes, streams a
// report frame to the UART transmitter: a header byte {overflow, count}, then
// each buffered address, oldest first, as a high byte and a low byte. One byte
// is sent per send/sendComplete handshake.
module sad_result_reporter #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              search_start,
    input  logic              match_strobe,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              search_done,
    output logic              uart_send,
    output logic [7:0]        uart_data,
    input  logic              uart_send_complete,
    output logic              busy,
    output logic              report_done,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_HDR,
        S_HI,
        S_LO,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic              ovf_q, ovf_d;
    logic              send_q, send_d;
    logic [7:0]        data_q, data_d;
    logic              mem_we;

    // Upper address bits, zero-extended into one byte.
    function automatic logic [7:0] hi_byte(input logic [ADDR_W-1:0] a);
        return 8'(a >> 8);
    endfunction

    function automatic logic [7:0] lo_byte(input logic [ADDR_W-1:0] a);
        return a[7:0];
    endfunction

    // Next-state, buffer bookkeeping and byte selection.
    // The header is built from the post-capture count/overflow so that a match
    // arriving together with search_done is included in the report.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        send_d   = 1'b0;
        data_d   = data_q;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (search_start) begin
                    state_d  = S_COLLECT;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end

            S_COLLECT: begin
                if (search_start) begin
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (match_strobe) begin
                        if (count_q == CW'(DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            count_d  = count_q + CW'(1);
                        end
                    end
                    if (search_done) begin
                        state_d  = S_HDR;
                        send_d   = 1'b1;
                        data_d   = {ovf_d, 7'(count_d)};
                        rem_d    = count_d;
                        rd_ptr_d = '0;
                    end
                end
            end

            S_HDR: begin
                if (uart_send_complete) begin
                    if (rem_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_HI;
                        send_d  = 1'b1;
                        data_d  = hi_byte(mem_q[rd_ptr_q]);
                    end
                end
            end

            S_HI: begin
                if (uart_send_complete) begin
                    state_d = S_LO;
                    send_d  = 1'b1;
                    data_d  = lo_byte(mem_q[rd_ptr_q]);
                end
            end

            S_LO: begin
                if (uart_send_complete) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    rem_d    = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_HI;
                        send_d  = 1'b1;
                        data_d  = hi_byte(mem_q[rd_ptr_d]);
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointers, counters and the registered UART request/data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            send_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            send_q   <= send_d;
            data_q   <= data_d;
        end
    end

    // Match address storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= match_addr;
        end
    end

    assign uart_send   = send_q;
    assign uart_data   = data_q;
    assign overflow    = ovf_q;
    assign report_done = (state_q == S_FIN);
    assign busy        = (state_q == S_COLLECT) || (state_q == S_HDR) ||
                         (state_q == S_HI)      || (state_q == S_LO);

endmodule

// File: tb/tb_sad_result_reporter.sv
// Directed bench for sad_result_reporter: drives searches and acts as the UART.
module tb_sad_result_reporter;

    logic        clock = 1'b0;
    logic        reset;
    logic        search_start;
    logic        match_strobe;
    logic [11:0] match_addr;
    logic        search_done;
    logic        uart_send;
    logic [7:0]  uart_data;
    logic        uart_send_complete;
    logic        busy;
    logic        report_done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes [0:8];
    logic [7:0] got;

    sad_result_reporter #(.ADDR_W(12), .DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .search_start       (search_start),
        .match_strobe       (match_strobe),
        .match_addr         (match_addr),
        .search_done        (search_done),
        .uart_send          (uart_send),
        .uart_data          (uart_data),
        .uart_send_complete (uart_send_complete),
        .busy               (busy),
        .report_done        (report_done),
        .overflow           (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        search_start = 1'b1;
        @(negedge clock);
        search_start = 1'b0;
    endtask

    task automatic pulse_match(input logic [11:0] a);
        match_strobe = 1'b1;
        match_addr   = a;
        @(negedge clock);
        match_strobe = 1'b0;
    endtask

    task automatic pulse_done();
        search_done = 1'b1;
        @(negedge clock);
        search_done = 1'b0;
    endtask

    // Wait for one uart_send, hold sendComplete back for 'hold' cycles while
    // watching for repeats or data changes, then acknowledge.
    task automatic get_byte(input int hold, input bit mid_start, output logic [7:0] b);
        int n = 0;
        bit ok = 1'b1;
        while (uart_send !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("send_seen", {31'b0, uart_send}, 32'd1);
        b = uart_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            search_start = (mid_start && i == hold / 2);
            if (uart_send !== 1'b0 || uart_data !== b || busy !== 1'b1) ok = 1'b0;
        end
        search_start = 1'b0;
        check("hold_stable", {31'b0, ok}, 32'd1);
        uart_send_complete = 1'b1;
        @(negedge clock);
        uart_send_complete = 1'b0;
    endtask

    task automatic get_frame(input string tag, input int n, input int hold, input bit mid_start);
        for (int i = 0; i < n; i++) begin
            get_byte(hold, mid_start && i == 1, got);
            check($sformatf("%s_byte%0d", tag, i), {24'b0, got}, {24'b0, exp_bytes[i]});
        end
        check({tag, "_done"}, {31'b0, report_done}, 32'd1);
        check({tag, "_busy_fin"}, {31'b0, busy}, 32'd0);
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'b0, report_done}, 32'd0);
    endtask

    initial begin
        bit quiet;
        int n;
        reset = 1'b0;
        search_start = 1'b0;
        match_strobe = 1'b0;
        match_addr = '0;
        search_done = 1'b0;
        uart_send_complete = 1'b0;
        #1;
        check("rst_send", {31'b0, uart_send}, 32'd0);
        check("rst_data", {24'b0, uart_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, report_done}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Ignored in IDLE
        pulse_match(12'h555);
        pulse_done();
        check("idle_ignore_busy", {31'b0, busy}, 32'd0);
        check("idle_ignore_send", {31'b0, uart_send}, 32'd0);

        // 1: reset mid-COLLECT, then an empty search
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        pulse_match(12'h111);
        pulse_match(12'h222);
        #2 reset = 1'b0;
        #1;
        check("t1_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_start();
        pulse_done();
        check("t1_latency", {31'b0, uart_send}, 32'd1);
        exp_bytes[0] = 8'h00;
        get_frame("t1", 1, 2, 1'b0);

        // 2: two matches
        pulse_start();
        pulse_match(12'h123);
        pulse_match(12'hABC);
        pulse_done();
        check("t2_latency", {31'b0, uart_send}, 32'd1);
        exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h01; exp_bytes[2] = 8'h23;
        exp_bytes[3] = 8'h0A; exp_bytes[4] = 8'hBC;
        get_frame("t2", 5, 3, 1'b0);

        // 3: overflow, six matches into four entries
        pulse_start();
        for (int i = 1; i <= 6; i++) pulse_match(12'(i));
        check("t3_ovf", {31'b0, overflow}, 32'd1);
        pulse_done();
        exp_bytes[0] = 8'h84;
        exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h01;
        exp_bytes[3] = 8'h00; exp_bytes[4] = 8'h02;
        exp_bytes[5] = 8'h00; exp_bytes[6] = 8'h03;
        exp_bytes[7] = 8'h00; exp_bytes[8] = 8'h04;
        get_frame("t3", 9, 1, 1'b0);
        check("t3_ovf_held", {31'b0, overflow}, 32'd1);
        repeat (3) @(negedge clock);
        check("t3_no_extra", {31'b0, uart_send}, 32'd0);

        // 4: match in the same cycle as search_done
        pulse_start();
        check("t4_ovf_clr", {31'b0, overflow}, 32'd0);
        match_strobe = 1'b1;
        match_addr = 12'h7FF;
        search_done = 1'b1;
        @(negedge clock);
        match_strobe = 1'b0;
        search_done = 1'b0;
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h07; exp_bytes[2] = 8'hFF;
        get_frame("t4", 3, 2, 1'b0);

        // 5: long stall on sendComplete, search_start mid-report ignored
        pulse_start();
        pulse_match(12'h5A5);
        pulse_done();
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h05; exp_bytes[2] = 8'hA5;
        get_frame("t5", 3, 100, 1'b1);
        check("t5_idle_after", {31'b0, busy}, 32'd0);

        // 6: reset during the HI wait
        pulse_start();
        pulse_match(12'h3C4);
        pulse_done();
        get_byte(2, 1'b0, got);
        check("t6_hdr", {24'b0, got}, 32'h01);
        n = 0;
        while (uart_send !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("t6_hi_send", {31'b0, uart_send}, 32'd1);
        check("t6_hi_data", {24'b0, uart_data}, 32'h03);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_send", {31'b0, uart_send}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        uart_send_complete = 1'b1;
        @(negedge clock);
        uart_send_complete = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            if (uart_send !== 1'b0 || busy !== 1'b0 || report_done !== 1'b0) quiet = 1'b0;
            @(negedge clock);
        end
        check("t6_quiet", {31'b0, quiet}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
